// File: rtl/wdt_timer_prog_if.sv
// wdt_timer_prog_if: control/status bundle of the programmable watchdog timer.
// Carries the optional warn output when WDT_WARN_EN is defined.
interface wdt_timer_prog_if #(parameter int TICK_W = 16);
  logic              count;
  logic              kick;
  logic              load;
  logic [TICK_W-1:0] load_val;
  logic              periodic;
  logic              clr_expired;
  logic [TICK_W-1:0] tick_cnt;
  logic              timeout;
  logic              expired;
`ifdef WDT_WARN_EN
  logic              warn;
`endif
  modport master (
    output count, kick, load, load_val, periodic, clr_expired,
    input `ifdef WDT_WARN_EN warn, `endif tick_cnt, timeout, expired
  );
  modport slave (
    input count, kick, load, load_val, periodic, clr_expired,
    output `ifdef WDT_WARN_EN warn, `endif tick_cnt, timeout, expired
  );
endinterface

// File: rtl/wdt_timer_prog.sv
// wdt_timer_prog: prescaled, runtime-loadable watchdog tick counter (one-shot/periodic).
// Optional WDT_WARN_EN adds a registered early-warning output.
module wdt_timer_prog #(
  parameter int CLK_DIV      = 50000,
  parameter int PRESC_W      = 16,
  parameter int TICK_W       = 16,
  parameter int DEFAULT_LOAD = 100
`ifdef WDT_WARN_EN
  , parameter int WARN_TICKS = 10
`endif
) (
  input logic clk,
  input logic rst,
  wdt_timer_prog_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} stateT;
  stateT state, stateNext;
  logic [PRESC_W-1:0] presc, prescNext;
  logic [TICK_W-1:0] tickCnt, tickCntNext, term, termNext;
  logic timeoutQ, timeoutNext, expiredQ, expiredNext;
  logic tick, terminal;
  assign tick     = bus.count && state != EXPIRED && presc == PRESC_W'(CLK_DIV - 1);
  assign terminal = tick && tickCnt >= term - TICK_W'(1);
  // Kick overrides everything on its edge, including a coincident terminal tick.
  always_comb begin
    stateNext   = state;
    prescNext   = presc;
    tickCntNext = tickCnt;
    timeoutNext = 1'b0;
    expiredNext = expiredQ & ~bus.clr_expired;
    termNext    = bus.load ? (bus.load_val == '0 ? TICK_W'(1) : bus.load_val) : term;
    if (bus.kick) begin
      prescNext   = '0;
      tickCntNext = '0;
      stateNext   = bus.count ? RUN : IDLE;
    end else begin
      if (bus.count && state != EXPIRED) prescNext = tick ? '0 : presc + PRESC_W'(1);
      if (tick) tickCntNext = tickCnt + TICK_W'(1);
      if (state == IDLE && bus.count) stateNext = RUN;
      if (state == EXPIRED && bus.clr_expired) stateNext = IDLE;
      if (terminal) begin
        timeoutNext = 1'b1;
        expiredNext = 1'b1;
        tickCntNext = bus.periodic ? '0 : term;
        stateNext   = bus.periodic ? RUN : EXPIRED;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      tickCnt  <= '0;
      term     <= TICK_W'(DEFAULT_LOAD);
      timeoutQ <= 1'b0;
      expiredQ <= 1'b0;
    end else begin
      state    <= stateNext;
      presc    <= prescNext;
      tickCnt  <= tickCntNext;
      term     <= termNext;
      timeoutQ <= timeoutNext;
      expiredQ <= expiredNext;
    end
  end
  assign bus.tick_cnt = tickCnt;
  assign bus.timeout  = timeoutQ;
  assign bus.expired  = expiredQ;
`ifdef WDT_WARN_EN
  logic [TICK_W-1:0] warnThr;
  logic warnQ, warnNext;
  // Evaluated on next-state values so warn lines up with the tick_cnt it refers to.
  assign warnThr  = term > TICK_W'(WARN_TICKS) ? term - TICK_W'(WARN_TICKS) : '0;
  assign warnNext = stateNext == RUN && !bus.kick && !terminal && tickCntNext >= warnThr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) warnQ <= 1'b0;
    else warnQ <= warnNext;
  end
  assign bus.warn = warnQ;
`endif
endmodule

// File: tb/tb_wdt_timer_prog.sv
// tb_wdt_timer_prog: directed self-checking bench for wdt_timer_prog (CLK_DIV=4, DEFAULT_LOAD=5).
module tb_wdt_timer_prog;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  wdt_timer_prog_if #(.TICK_W(16)) bus ();
  wdt_timer_prog #(
    .CLK_DIV(4), .PRESC_W(16), .TICK_W(16), .DEFAULT_LOAD(5)
`ifdef WDT_WARN_EN
    , .WARN_TICKS(1)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.count = 0; bus.kick = 0; bus.load = 0; bus.load_val = '0;
    bus.periodic = 0; bus.clr_expired = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load_term(input logic [15:0] v, input logic per);
    bus.load = 1; bus.load_val = v; bus.periodic = per;
    step(1);
    bus.load = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.tick_cnt, bus.timeout, bus.expired} !== 18'd0) begin
      fails++;
      $display("FAIL reset_vals: tick_cnt=%0d timeout=%b expired=%b want 0/0/0", bus.tick_cnt, bus.timeout, bus.expired);
    end
  endtask

  task automatic test_oneshot();
    int pulses;
    do_reset();
    load_term(16'd3, 1'b0);
    bus.count = 1;
    step(11);
    tests++;
    if (bus.timeout !== 1'b0 || bus.tick_cnt !== 16'd2) begin
      fails++;
      $display("FAIL oneshot_e11: timeout=%b tick_cnt=%0d want 0/2", bus.timeout, bus.tick_cnt);
    end
    step(1);
    tests++;
    if (bus.timeout !== 1'b1 || bus.tick_cnt !== 16'd3 || bus.expired !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_e12: timeout=%b tick_cnt=%0d expired=%b want 1/3/1", bus.timeout, bus.tick_cnt, bus.expired);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.timeout === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || bus.tick_cnt !== 16'd3 || bus.expired !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_hold: pulses=%0d tick_cnt=%0d expired=%b want 0/3/1", pulses, bus.tick_cnt, bus.expired);
    end
    bus.clr_expired = 1;
    step(1);
    bus.clr_expired = 0;
    tests++;
    if (bus.expired !== 1'b0) begin
      fails++;
      $display("FAIL clr_expired: expired=%b want 0", bus.expired);
    end
  endtask

  task automatic test_periodic();
    do_reset();
    load_term(16'd3, 1'b1);
    bus.count = 1;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      tests++;
      if (bus.timeout !== (e % 12 == 0) || bus.tick_cnt !== 16'((e / 4) % 3) || bus.expired !== (e >= 12)) begin
        fails++;
        $display("FAIL periodic_e%0d: timeout=%b tick_cnt=%0d expired=%b want %b/%0d/%b",
                 e, bus.timeout, bus.tick_cnt, bus.expired, e % 12 == 0, (e / 4) % 3, e >= 12);
      end
    end
  endtask

  task automatic test_pause();
    int bad;
    do_reset();
    load_term(16'd3, 1'b0);
    bus.count = 1;
    step(6);
    bus.count = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.tick_cnt !== 16'd1 || bus.timeout !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL pause_hold: %0d paused cycles moved, want 0", bad);
    end
    bus.count = 1;
    step(5);
    tests++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL pause_e21: timeout=%b want 0", bus.timeout);
    end
    step(1);
    tests++;
    if (bus.timeout !== 1'b1) begin
      fails++;
      $display("FAIL pause_e22: timeout=%b want 1", bus.timeout);
    end
  endtask

  task automatic test_kick();
    do_reset();
    load_term(16'd3, 1'b0);
    bus.count = 1;
    step(11);
    bus.kick = 1;
    step(1);
    bus.kick = 0;
    tests++;
    if (bus.timeout !== 1'b0 || bus.tick_cnt !== 16'd0 || bus.expired !== 1'b0) begin
      fails++;
      $display("FAIL kick_e12: timeout=%b tick_cnt=%0d expired=%b want 0/0/0", bus.timeout, bus.tick_cnt, bus.expired);
    end
    step(3);
    tests++;
    if (bus.tick_cnt !== 16'd0) begin
      fails++;
      $display("FAIL kick_presc: tick_cnt=%0d at e15 want 0", bus.tick_cnt);
    end
    step(1);
    tests++;
    if (bus.tick_cnt !== 16'd1) begin
      fails++;
      $display("FAIL kick_presc16: tick_cnt=%0d at e16 want 1", bus.tick_cnt);
    end
    step(7);
    tests++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL kick_e23: timeout=%b want 0", bus.timeout);
    end
    step(1);
    tests++;
    if (bus.timeout !== 1'b1 || bus.expired !== 1'b1) begin
      fails++;
      $display("FAIL kick_e24: timeout=%b expired=%b want 1/1", bus.timeout, bus.expired);
    end
  endtask

  task automatic test_load();
    do_reset();
    load_term(16'd5, 1'b1);
    bus.count = 1;
    step(8);
    tests++;
    if (bus.tick_cnt !== 16'd2) begin
      fails++;
      $display("FAIL load_pre: tick_cnt=%0d want 2", bus.tick_cnt);
    end
    load_term(16'd1, 1'b1);
    step(2);
    tests++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL load_e11: timeout=%b want 0", bus.timeout);
    end
    step(1);
    tests++;
    if (bus.timeout !== 1'b1 || bus.tick_cnt !== 16'd0) begin
      fails++;
      $display("FAIL load_e12: timeout=%b tick_cnt=%0d want 1/0", bus.timeout, bus.tick_cnt);
    end
    bus.load = 1; bus.load_val = 16'd0;
    for (int e = 13; e <= 24; e++) begin
      step(1);
      bus.load = 0;
      tests++;
      if (bus.timeout !== (e % 4 == 0) || bus.tick_cnt !== 16'd0) begin
        fails++;
        $display("FAIL load0_e%0d: timeout=%b tick_cnt=%0d want %b/0", e, bus.timeout, bus.tick_cnt, e % 4 == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_term(16'd3, 1'b1);
    bus.count = 1;
    step(20);
    tests++;
    if (bus.tick_cnt !== 16'd2 || bus.expired !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: tick_cnt=%0d expired=%b want 2/1", bus.tick_cnt, bus.expired);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus.tick_cnt, bus.timeout, bus.expired} !== 18'd0) begin
      fails++;
      $display("FAIL rstmid_async: tick_cnt=%0d timeout=%b expired=%b want 0/0/0", bus.tick_cnt, bus.timeout, bus.expired);
    end
    #1 rst = 1'b1;
    step(19);
    tests++;
    if (bus.timeout !== 1'b0 || bus.tick_cnt !== 16'd4) begin
      fails++;
      $display("FAIL rstmid_e19: timeout=%b tick_cnt=%0d want 0/4", bus.timeout, bus.tick_cnt);
    end
    step(1);
    tests++;
    if (bus.timeout !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_default_term: timeout=%b want 1", bus.timeout);
    end
  endtask

`ifdef WDT_WARN_EN
  task automatic test_warn();
    do_reset();
    load_term(16'd3, 1'b0);
    bus.count = 1;
    step(7);
    tests++;
    if (bus.warn !== 1'b0) begin
      fails++;
      $display("FAIL warn_e7: warn=%b want 0", bus.warn);
    end
    step(1);
    tests++;
    if (bus.warn !== 1'b1) begin
      fails++;
      $display("FAIL warn_e8: warn=%b want 1", bus.warn);
    end
    step(4);
    tests++;
    if (bus.warn !== 1'b0 || bus.timeout !== 1'b1) begin
      fails++;
      $display("FAIL warn_e12: warn=%b timeout=%b want 0/1", bus.warn, bus.timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_kick();
    test_load();
    test_reset_mid();
`ifdef WDT_WARN_EN
    test_warn();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
